// File: rtl/rvvi_buffer.sv
// rvvi_buffer: elastic first-word-fall-through RVVI record FIFO with a hysteretic core stall.
// Define RVVI_BUFFER_STATS_EN to build the DropCount / HighWater statistics counters.
module rvvi_buffer #(
    parameter int XLEN             = 64,
    parameter int MAX_CSRS         = 5,
    parameter int DEPTH            = 16,
    parameter int STALL_THRESHOLD  = 12,
    parameter int RESUME_THRESHOLD = 4,
    localparam int W  = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] rvvi,
    output logic [W-1:0] RvviOut,
    output logic         RvviValidOut,
    input  logic         RvviReady,
    output logic         BufferStall,
    output logic [AW:0]  FillLevel,
    output logic         Overflow,
    output logic [31:0]  DropCount,
    output logic [AW:0]  HighWater
);
    typedef enum logic {RUN, HOLD} state_t;
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_T  = (AW+1)'(STALL_THRESHOLD);
    localparam logic [AW:0] RESUME_T = (AW+1)'(RESUME_THRESHOLD);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    state_t        state;
    logic          push, pop, drop;

    assign pop          = RvviValidOut && RvviReady;
    assign push         = valid && (count != FULL || pop);
    assign drop         = valid && !push;
    assign RvviValidOut = count != '0;
    assign RvviOut      = RvviValidOut ? mem[rptr] : '0;
    assign FillLevel    = count;

    always_ff @(posedge clk) if (push) mem[wptr] <= rvvi;

    // Stall decisions use the registered fill level, so BufferStall trails the crossing by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            Overflow    <= 1'b0;
            state       <= RUN;
            BufferStall <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (drop) Overflow <= 1'b1;
            case (state)
                RUN:  if (count >= STALL_T) begin
                    state       <= HOLD;
                    BufferStall <= 1'b1;
                end
                HOLD: if (count <= RESUME_T) begin
                    state       <= RUN;
                    BufferStall <= 1'b0;
                end
            endcase
        end
    end

`ifdef RVVI_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            DropCount <= '0;
            HighWater <= '0;
        end else begin
            if (drop && DropCount != '1) DropCount <= DropCount + 32'd1;
            if (count > HighWater) HighWater <= count;
        end
    end
`else
    assign DropCount = '0;
    assign HighWater = '0;
`endif
endmodule

// File: tb/tb_rvvi_buffer.sv
// tb_rvvi_buffer: vector table, directed corner sequences and random traffic against a queue model.
module tb_rvvi_buffer;
    localparam int XLEN     = 32;
    localparam int MAX_CSRS = 5;
    localparam int DEPTH    = 16;
    localparam int W        = 72 + 5*XLEN + MAX_CSRS*(XLEN+16);
    localparam int AW       = $clog2(DEPTH);

    logic         clk = 0, reset = 1, valid = 0, RvviReady = 0;
    logic [W-1:0] rvvi = '0;
    logic [W-1:0] RvviOut;
    logic         RvviValidOut, BufferStall, Overflow;
    logic [AW:0]  FillLevel, HighWater;
    logic [31:0]  DropCount;

    rvvi_buffer #(.XLEN(XLEN), .MAX_CSRS(MAX_CSRS), .DEPTH(DEPTH),
                  .STALL_THRESHOLD(12), .RESUME_THRESHOLD(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .rvvi(rvvi),
        .RvviOut(RvviOut), .RvviValidOut(RvviValidOut), .RvviReady(RvviReady),
        .BufferStall(BufferStall), .FillLevel(FillLevel), .Overflow(Overflow),
        .DropCount(DropCount), .HighWater(HighWater)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [W-1:0] q[$];
    bit m_ovf, m_stall;
    longint unsigned m_drops;
    int m_hw;

    function automatic logic [W-1:0] mk(input int unsigned s);
        logic [W-1:0] r = '0;
        for (int i = 0; i < (W+31)/32; i++) r = {r[W-33:0], s*32'h9E3779B9 + i*32'h01000193 + 32'd1};
        return r;
    endfunction

    task automatic chk_i(input string n, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic chk_d(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Advance one clock with the currently driven inputs, update the model, compare every output.
    task automatic step();
        int sz = q.size();
        bit pop = sz != 0 && RvviReady;
        bit push = valid && (sz < DEPTH || pop);
        bit drop = valid && !push;
        logic [W-1:0] d = rvvi;
        @(posedge clk); #1;
        if (reset) begin
            q.delete(); m_ovf = 0; m_stall = 0; m_drops = 0; m_hw = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            if (drop) begin
                m_ovf = 1;
                if (m_drops < 64'hFFFF_FFFF) m_drops++;
            end
            if (!m_stall && sz >= 12) m_stall = 1;
            else if (m_stall && sz <= 4) m_stall = 0;
            if (sz > m_hw) m_hw = sz;
        end
        chk_i("fill", FillLevel, q.size());
        chk_i("valid_out", RvviValidOut, q.size() != 0);
        chk_d("data_out", RvviOut, q.size() != 0 ? q[0] : '0);
        chk_i("stall", BufferStall, m_stall);
        chk_i("overflow", Overflow, m_ovf);
`ifdef RVVI_BUFFER_STATS_EN
        chk_i("drop_count", DropCount, m_drops);
        chk_i("high_water", HighWater, m_hw);
`else
        chk_i("drop_count", DropCount, 0);
        chk_i("high_water", HighWater, 0);
`endif
    endtask

    task automatic do_reset();
        reset = 1; valid = 0; RvviReady = 0;
        step();
        reset = 0;
    endtask

    task automatic drive(input bit v, input int unsigned tag, input bit r);
        valid = v; rvvi = mk(tag); RvviReady = r;
        step();
    endtask

    typedef struct {
        bit          v;
        int unsigned tag;
        bit          rdy;
        int          fill;
        bit          vout;
        int unsigned otag;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 100, 0, 1, 1, 100};
        for (int i = 1; i <= 5; i++) tbl[i] = '{0, 0, 0, 1, 1, 100};
        tbl[6] = '{0, 0, 1, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 0, 0, 0};

        do_reset();
        chk_i("reset_fill", FillLevel, 0);
        chk_i("reset_valid", RvviValidOut, 0);
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].tag, tbl[i].rdy);
            chk_i("tbl_fill", FillLevel, tbl[i].fill);
            chk_i("tbl_valid", RvviValidOut, tbl[i].vout);
            chk_d("tbl_data", RvviOut, tbl[i].vout ? mk(tbl[i].otag) : '0);
        end

        // Stall hysteresis timing.
        do_reset();
        for (int i = 1; i <= 12; i++) drive(1, i, 0);
        chk_i("stall_at_12_fill", FillLevel, 12);
        chk_i("stall_at_12", BufferStall, 0);
        drive(0, 0, 0);
        chk_i("stall_after_12", BufferStall, 1);
        for (int i = 0; i < 7; i++) drive(0, 0, 1);
        chk_i("stall_fill5_fill", FillLevel, 5);
        chk_i("stall_fill5", BufferStall, 1);
        drive(0, 0, 1);
        chk_i("stall_fill4_fill", FillLevel, 4);
        chk_i("stall_fill4", BufferStall, 1);
        drive(0, 0, 0);
        chk_i("stall_release", BufferStall, 0);

        // Overflow with drops, then drain order.
        do_reset();
        for (int i = 1; i <= 20; i++) drive(1, i, 0);
        chk_i("ovf_fill", FillLevel, 16);
        chk_i("ovf_flag", Overflow, 1);
`ifdef RVVI_BUFFER_STATS_EN
        chk_i("ovf_drops", DropCount, 4);
        chk_i("ovf_hw", HighWater, 16);
`else
        chk_i("ovf_drops", DropCount, 0);
        chk_i("ovf_hw", HighWater, 0);
`endif
        for (int i = 1; i <= 16; i++) begin
            chk_d("drain_order", RvviOut, mk(i));
            drive(0, 0, 1);
        end
        chk_i("drain_empty", RvviValidOut, 0);

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 1; i <= 16; i++) drive(1, i, 0);
        for (int i = 17; i <= 19; i++) drive(1, i, 1);
        chk_i("full_pp_fill", FillLevel, 16);
        chk_i("full_pp_ovf", Overflow, 0);
        chk_d("full_pp_head", RvviOut, mk(4));
        for (int i = 0; i < 16; i++) drive(0, 0, 1);

        // Streaming push/pop every cycle.
        do_reset();
        for (int i = 0; i < 100; i++) drive(1, 1000 + i, 1);
        chk_i("stream_fill", FillLevel, 1);
        chk_i("stream_stall", BufferStall, 0);
        chk_d("stream_head", RvviOut, mk(1099));

        // Reset mid-operation while stalled and overflowed.
        do_reset();
        for (int i = 1; i <= 17; i++) drive(1, i, 0);
        for (int i = 0; i < 7; i++) drive(0, 0, 1);
        chk_i("pre_rst_fill", FillLevel, 9);
        chk_i("pre_rst_stall", BufferStall, 1);
        chk_i("pre_rst_ovf", Overflow, 1);
        do_reset();
        chk_i("rst_fill", FillLevel, 0);
        chk_i("rst_valid", RvviValidOut, 0);
        chk_i("rst_stall", BufferStall, 0);
        chk_i("rst_ovf", Overflow, 0);

        // Random traffic with phases biased toward filling and draining.
        for (int p = 0; p < 6; p++) begin
            int pv = (p % 2 == 0) ? 85 : 30;
            int pr = (p % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 120; i++)
                drive($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
